pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It moves an opaque payload plus a side-effect control field from one stage to the next under a valid/ready handshake. It supports downstream back-pressure, a synchronous flush, and bubble masking of side-effect controls. An optional skid entry registers `in_ready` so that no combinational ready path crosses stages.

## Interface
- `DATA_W`, 256: payload width in bits (pc, inst, operands, results; concatenated by the instantiating stage).
- `CTRL_W`, 4: side-effect control width (rd_w_en, csr_w_en, mem_w_en, …); forced to 0 whenever the stage holds no valid beat.
- `RESET_DATA`, 0: payload value at reset.
- `clk`  in  1  stage clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held beats; also drops any input beat offered in the same cycle.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream side-effect controls.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `out_data`  out  DATA_W  held payload.
- `out_ctrl`  out  CTRL_W  held controls; 0 when `out_valid`=0.
- `occupancy`  out  2  beats held: 0, 1 or 2 (2 only with skid).

## Operation
- Accept: `in_valid & in_ready`. Drain: `out_valid & out_ready`.
- Base mode (one entry, main register):
  - `in_ready = ~flush & (~out_valid | out_ready)`.
  - On accept, the main register loads `in_data`/`in_ctrl` and `out_valid` is set.
  - On drain without accept, `out_valid` is cleared and the ctrl register is cleared. The data register holds its value.
- Skid mode: state machine `EMPTY` / `FULL` / `SKID`.
  - `in_ready = ~flush & (state != SKID)`. `in_ready` depends only on registered state and `flush`.
  - `EMPTY`: accept → load main → `FULL`.
  - `FULL`:
    - accept & drain → load main → `FULL`.
    - accept & no drain → load skid → `SKID`.
    - drain only → `EMPTY`.
  - `SKID`: drain → main ← skid → `FULL`. Input is never accepted in this state.
- Flush:
  - All valids cleared and all ctrl registers zeroed next cycle; state → `EMPTY`.
  - Flush overrides a simultaneous accept and a simultaneous drain. A drain in the flush cycle is still seen downstream, because `out_valid` is combinational from the current state.
- Order is preserved: the skid beat is always older than any later input.
- `occupancy` = number of valid entries, registered.

## Timing
- Latency: a beat accepted at edge N is visible on `out_*` after edge N; 1 cycle.
- Throughput: 1 beat/cycle whenever `out_ready`=1.
- Reset (async assert, sync release):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=RESET_DATA, `occupancy`=0, state `EMPTY`.
  - `in_ready`=1 after reset while `flush`=0.
- Reset asserted mid-transfer discards all beats immediately, with no wait for the clock.
- `out_data`/`out_ctrl` are stable while `out_valid & ~out_ready`.
- `in_valid` with `in_ready`=0 has no effect; upstream holds its beat.

## Configuration
- `PIPE_SKID_EN` defined:
  - Skid entry and the three-state machine are compiled in.
  - `in_ready` is registered-only.
  - `occupancy` can reach 2.
- `PIPE_SKID_EN` undefined:
  - Single entry only.
  - `in_ready` is combinational from `out_ready`.
  - `occupancy` ≤ 1.
  - No skid storage is synthesised.

## Structure
- Package `pipe_pkg`:
  - `pipe_state_t` enum (`EMPTY`, `FULL`, `SKID`, 2 bits).
  - `OCC_W` = 2.
- Storage uses the existing `Reg` primitive for the main and skid entries. Ctrl entries use a reset tied to `~rst_n | clear`.
- One sub-module: `pipe_skid_buf`, which holds the skid data/ctrl entry and its valid. It is instantiated only under `PIPE_SKID_EN`.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `out_ctrl`=0, `out_data`=RESET_DATA, `occupancy`=0.
- Streaming: `out_ready`=1; inputs 0x11, 0x22, 0x33 on consecutive cycles → same values on `out_data` one cycle later each, with no gaps.
- Back-pressure (skid):
  - Accept 0xA, then `out_ready`=0 and offer 0xB → `occupancy`=2, `in_ready`=0.
  - Raise `out_ready` → outputs 0xA then 0xB, in order.
- Bubble masking: accept a beat with `in_ctrl`=4'b1111, drain it, then `in_valid`=0 → `out_valid`=0 and `out_ctrl`=4'b0000 next cycle. `out_data` holds its last value.
- Flush collision: stage `FULL` with 0x5, assert `flush` with `in_valid`=1 (0x6) → next cycle `out_valid`=0, `occupancy`=0, and 0x6 never appears.
- Async reset mid-stall: `occupancy`=2, drop `rst_n` between edges → outputs cleared immediately. After release, `in_ready`=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types and constants for the generic pipeline stage register.
//
// Contents:
//   pipe_state_t : occupancy state of a stage (EMPTY / FULL / SKID)
//   OCC_W        : width of the occupancy count output
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf -- second (skid) entry of a pipeline stage register.
// Catches the beat accepted in the cycle where the main entry stalls, so the
// upstream ready can be computed purely from registered state.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous clear of the entry (valid and ctrl zeroed)
//   load            : capture in_data/in_ctrl and mark the entry valid
//   in_data/in_ctrl : beat to capture
//   vld             : entry holds a beat
//   data/ctrl       : held beat; ctrl is zero whenever vld is zero
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 256,
    parameter int                CTRL_W     = 4,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              vld_q,  vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (clear) begin
            // Payload is left in place; only side-effect controls must die.
            vld_d  = 1'b0;
            ctrl_d = '0;
        end else if (load) begin
            vld_d  = 1'b1;
            data_d = in_data;
            ctrl_d = in_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= RESET_DATA;
            ctrl_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;
    assign ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic pipeline stage register with valid/ready handshake,
// synchronous flush and bubble masking of side-effect controls.
//
// Build option: define PIPE_SKID_EN to add a skid entry (pipe_skid_buf) and
// a three-state controller so in_ready is driven from registered state only.
// Without it the stage is a single entry whose in_ready follows out_ready.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : kill all held beats and any beat offered this cycle
//   in_valid/in_ready   : upstream handshake
//   in_data/in_ctrl     : upstream payload and side-effect controls
//   out_valid/out_ready : downstream handshake
//   out_data/out_ctrl   : held payload and controls (ctrl is 0 when invalid)
//   occupancy           : number of beats held (0..1, or 0..2 with skid)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 256,
    parameter int                CTRL_W     = 4,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    logic              accept;
    logic              drain;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

`ifdef PIPE_SKID_EN

    pipe_state_t       state_q, state_d;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Both outputs come from registered state (plus flush), never out_ready.
    assign in_ready  = ~flush & (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = OCC_W'(out_valid) + OCC_W'(skid_vld);

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_clear  = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        // Main is stalled: the new (younger) beat waits behind it.
                        skid_load = 1'b1;
                        state_d   = SKID;
                    end else if (drain) begin
                        main_ctrl_d = '0;
                        state_d     = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        main_data_d = skid_data;
                        main_ctrl_d = skid_ctrl;
                        skid_clear  = 1'b1;
                        state_d     = FULL;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    skid_clear  = 1'b1;
                    state_d     = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (skid_clear),
        .load    (skid_load),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .vld     (skid_vld),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

`else

    logic main_vld_q, main_vld_d;

    // Combinational ready: a full entry can take a new beat while it drains.
    assign in_ready  = ~flush & (~main_vld_q | out_ready);
    assign out_valid = main_vld_q;
    assign occupancy = OCC_W'(main_vld_q);

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
        end else if (accept) begin
            main_vld_d  = 1'b1;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (drain) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
        end
    end

`endif

    // Main entry storage; ctrl is kept zero whenever the entry is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= RESET_DATA;
            main_ctrl_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    assign out_data = main_data_q;
    assign out_ctrl = main_ctrl_q;

endmodule
